// File: rtl/bit32adder.sv
// Registered 32-bit ripple-carry adder built from explicit 1-bit full-adder stages.
// Define BIT32ADDER_OVF_EN to add the registered signed-overflow output 'ovf'.

module bit32adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module bit32adder #(
  parameter int WIDTH   = 32,
  parameter int CIN_LSB = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH:0]   f,
  output logic [WIDTH:0]   cin
`ifdef BIT32ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH != 32) begin : g_bad_width
    $error("bit32adder: only WIDTH=32 is supported");
  end
  if (CIN_LSB != 0 && CIN_LSB != 1) begin : g_bad_cin
    $error("bit32adder: CIN_LSB must be 0 or 1");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = (CIN_LSB != 0);

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    bit32adder_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Results only update on a valid capture; out_valid tracks in_valid with one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= '0;
      cin       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        f   <= {carry[WIDTH], sum};
        cin <= carry;
      end
    end
  end

`ifdef BIT32ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_bit32adder.sv
// Self-checking bench for bit32adder: directed corner cases, hold, async reset and
// random back-to-back traffic against an arithmetic reference model.

module tb_bit32adder;

  localparam int CIN = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [32:0] f;
  logic [32:0] cin;
`ifdef BIT32ADDER_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  bit32adder #(.WIDTH(32), .CIN_LSB(CIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .f         (f),
    .cin       (cin)
`ifdef BIT32ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || f !== 33'd0 || cin !== 33'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got out_valid=%b f=%h cin=%h, expected 0/0/0", out_valid, f, cin);
    end
`ifdef BIT32ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b expected 0", ovf);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || f !== 33'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got out_valid=%b f=%h, expected 0/0", out_valid, f);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [32:0] tf [4];
    logic [32:0] tc [4];
    logic        to [4];
    ta[0] = 32'd100;        tb[0] = 32'd200; tf[0] = 33'h0_0000_012C; tc[0] = 33'h0_0000_0180; to[0] = 1'b0;
    ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'd1;   tf[1] = 33'h1_0000_0000; tc[1] = 33'h1_FFFF_FFFE; to[1] = 1'b0;
    ta[2] = 32'h7FFF_FFFF;  tb[2] = 32'd1;   tf[2] = 33'h0_8000_0000; tc[2] = 33'h0_FFFF_FFFE; to[2] = 1'b1;
    ta[3] = 32'd0;          tb[3] = 32'd0;   tf[3] = 33'd0;           tc[3] = 33'd0;           to[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = ta[i];
      b = tb[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed%0d_valid: got %b expected 1", i, out_valid);
      end
      checks++;
      if (f !== tf[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_f: got %h expected %h", i, f, tf[i]);
      end
      checks++;
      if (cin !== tc[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_cin: got %h expected %h", i, cin, tc[i]);
      end
`ifdef BIT32ADDER_OVF_EN
      checks++;
      if (ovf !== to[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_ovf: got %b expected %b", i, ovf, to[i]);
      end
`else
      if (to[i] === 1'bx) $display("[TB] unexpected table entry");
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    a = 32'h7FFF_FFFF;
    b = 32'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'h1234_5678;
    b = 32'h0F0F_0F0F;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || f !== 33'h0_8000_0000 || cin !== 33'h0_FFFF_FFFE) begin
        errors++;
        $display("[TB] FAIL hold%0d: got out_valid=%b f=%h cin=%h, expected 0/080000000/0fffffffe", i, out_valid, f, cin);
      end
`ifdef BIT32ADDER_OVF_EN
      checks++;
      if (ovf !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold%0d_ovf: got %b expected 1", i, ovf);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'h7FFF_FFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1 || f !== 33'h1_7FFF_FFFE) begin
      errors++;
      $display("[TB] FAIL pre_reset: got out_valid=%b f=%h, expected 1/17ffffffe", out_valid, f);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || f !== 33'd0 || cin !== 33'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got out_valid=%b f=%h cin=%h, expected 0/0/0", out_valid, f, cin);
    end
`ifdef BIT32ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_ovf: got %b expected 0", ovf);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || f !== 33'd0) begin
      errors++;
      $display("[TB] FAIL reset_held: got out_valid=%b f=%h, expected 0/0", out_valid, f);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'd5;
    b = 32'd7;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || f !== 33'd12) begin
      errors++;
      $display("[TB] FAIL first_capture: got out_valid=%b f=%h, expected 1/00000000c", out_valid, f);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_f;
    logic [32:0] exp_cin;
    logic        exp_ovf;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      in_valid = 1'b1;
      exp_f   = {1'b0, a} + {1'b0, b} + 33'(CIN);
      exp_cin = exp_f ^ {1'b0, a} ^ {1'b0, b};
      exp_ovf = (a[31] == b[31]) && (exp_f[31] != a[31]);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || f !== exp_f) begin
        errors++;
        $display("[TB] FAIL b2b%0d_f: a=%h b=%h got valid=%b f=%h expected 1/%h", i, a, b, out_valid, f, exp_f);
      end
      checks++;
      if (cin !== exp_cin) begin
        errors++;
        $display("[TB] FAIL b2b%0d_cin: a=%h b=%h got %h expected %h", i, a, b, cin, exp_cin);
      end
`ifdef BIT32ADDER_OVF_EN
      checks++;
      if (ovf !== exp_ovf) begin
        errors++;
        $display("[TB] FAIL b2b%0d_ovf: a=%h b=%h got %b expected %b", i, a, b, ovf, exp_ovf);
      end
`else
      if (exp_ovf === 1'bx) $display("[TB] unexpected model state");
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
